// File: rtl/id_ex_hazard_pipe_if.sv
// Bundle of ID-side inputs and EX-side outputs for the ID/EX pipeline register.
// The pipe itself takes the slave view; the ID stage / bench takes the master view.
interface id_ex_hazard_pipe_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) ();
  logic              valid_in;
  logic [31:0]       instruction_in;
  logic [XLEN-1:0]   PC_in;
  logic [XLEN-1:0]   data1_in;
  logic [XLEN-1:0]   data2_in;
  logic [XLEN-1:0]   immediate_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic              busywait;
  logic              flush;

  logic              stall_ID;
  logic              valid_out;
  logic [31:0]       instruction_out;
  logic [XLEN-1:0]   PC_out;
  logic [XLEN-1:0]   data1_out;
  logic [XLEN-1:0]   data2_out;
  logic [XLEN-1:0]   immediate_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output valid_in, instruction_in, PC_in, data1_in, data2_in, immediate_in,
           ctrl_in, busywait, flush,
    input  stall_ID, valid_out, instruction_out, PC_out, data1_out, data2_out,
           immediate_out, ctrl_out, stall_cnt, bubble_cnt
  );

  modport slave (
    input  valid_in, instruction_in, PC_in, data1_in, data2_in, immediate_in,
           ctrl_in, busywait, flush,
    output stall_ID, valid_out, instruction_out, PC_out, data1_out, data2_out,
           immediate_out, ctrl_out, stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/id_ex_hazard_pipe.sv
// ID->EX pipeline register with load-use hazard detection, bubble insertion,
// branch flush, memory-stall freeze and saturating stall/bubble counters.
module id_ex_hazard_pipe #(
  parameter int XLEN            = 32,
  parameter int CTRL_W          = 16,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input logic                clk,
  input logic                reset,
  id_ex_hazard_pipe_if.slave bus
);
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int HCNT_W = $clog2(LOAD_USE_CYCLES) + 1;
  localparam logic [HCNT_W-1:0] HCNT_INIT = HCNT_W'(LOAD_USE_CYCLES - 1);

  typedef enum logic {RUN = 1'b0, HAZ = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   data1_q, data1_d;
  logic [XLEN-1:0]   data2_q, data2_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic       load_bubble;
  logic       capture;
  logic       hazard;
  logic       stall_id;
  logic [4:0] rd;
  logic [6:0] opcode;
  logic [1:0] src_used;
  logic [1:0] src_match;

  assign rd     = instr_q[11:7];
  assign opcode = bus.instruction_in[6:0];

  // src_used[0] = rs1 read, src_used[1] = rs2 read, decoded from the ID opcode.
  always_comb begin
    src_used = 2'b11;
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111: src_used = 2'b00;
      7'b0010011, 7'b0000011, 7'b1100111: src_used = 2'b01;
      default:                            src_used = 2'b11;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_match[gi] = src_used[gi] &
                             (bus.instruction_in[15 + 5*gi +: 5] == rd);
    end
  endgenerate

  assign hazard   = valid_q & ctrl_q[1] & (rd != 5'd0) & bus.valid_in & (|src_match);
  assign stall_id = ~bus.flush & (((state_q == RUN) & hazard) | (state_q == HAZ));

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    load_bubble = 1'b0;
    capture     = 1'b0;
    if (!bus.busywait) begin
      if (bus.flush) begin
        load_bubble = 1'b1;
        state_d     = RUN;
        hcnt_d      = '0;
      end else if ((state_q == RUN) && hazard) begin
        load_bubble = 1'b1;
        if (LOAD_USE_CYCLES > 1) begin
          state_d = HAZ;
          hcnt_d  = HCNT_INIT;
        end
      end else if (state_q == HAZ) begin
        load_bubble = 1'b1;
        hcnt_d      = hcnt_q - HCNT_W'(1);
        if (hcnt_d == '0) state_d = RUN;
      end else begin
        capture = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    data1_d = data1_q;
    data2_d = data2_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    if (load_bubble) begin
      valid_d = 1'b0;
      instr_d = NOP;
      pc_d    = '0;
      data1_d = '0;
      data2_d = '0;
      imm_d   = '0;
      ctrl_d  = '0;
    end else if (capture) begin
      valid_d = bus.valid_in;
      instr_d = bus.instruction_in;
      pc_d    = bus.PC_in;
      data1_d = bus.data1_in;
      data2_d = bus.data2_in;
      imm_d   = bus.immediate_in;
      ctrl_d  = bus.valid_in ? bus.ctrl_in : '0;
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if ((stall_id || bus.busywait) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (load_bubble && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      hcnt_q       <= '0;
      valid_q      <= 1'b0;
      instr_q      <= NOP;
      pc_q         <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      imm_q        <= '0;
      ctrl_q       <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      imm_q        <= imm_d;
      ctrl_q       <= ctrl_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.stall_ID        = stall_id;
  assign bus.valid_out       = valid_q;
  assign bus.instruction_out = instr_q;
  assign bus.PC_out          = pc_q;
  assign bus.data1_out       = data1_q;
  assign bus.data2_out       = data2_q;
  assign bus.immediate_out   = imm_q;
  assign bus.ctrl_out        = ctrl_q;
  assign bus.stall_cnt       = stall_cnt_q;
  assign bus.bubble_cnt      = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_hazard_pipe.sv
// Bench for id_ex_hazard_pipe: two instances (1-cycle and 3-cycle load-use, narrow
// counters on the second) share one ID stimulus and are checked against a model.
module tb_id_ex_hazard_pipe;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in, busywait, flush;
  logic [31:0] instr_in, pc_in, d1_in, d2_in, imm_in;
  logic [15:0] ctrl_in;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_hazard_pipe_if #(.XLEN(32), .CTRL_W(16), .CNT_W(16)) if0 ();
  id_ex_hazard_pipe_if #(.XLEN(32), .CTRL_W(16), .CNT_W(4))  if1 ();

  assign if0.valid_in = valid_in;  assign if1.valid_in = valid_in;
  assign if0.instruction_in = instr_in;  assign if1.instruction_in = instr_in;
  assign if0.PC_in = pc_in;  assign if1.PC_in = pc_in;
  assign if0.data1_in = d1_in;  assign if1.data1_in = d1_in;
  assign if0.data2_in = d2_in;  assign if1.data2_in = d2_in;
  assign if0.immediate_in = imm_in;  assign if1.immediate_in = imm_in;
  assign if0.ctrl_in = ctrl_in;  assign if1.ctrl_in = ctrl_in;
  assign if0.busywait = busywait;  assign if1.busywait = busywait;
  assign if0.flush = flush;  assign if1.flush = flush;

  id_ex_hazard_pipe #(.XLEN(32), .CTRL_W(16), .LOAD_USE_CYCLES(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  id_ex_hazard_pipe #(.XLEN(32), .CTRL_W(16), .LOAD_USE_CYCLES(3), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .bus(if1));

  // ---------------- reference model (one slot per instance) ----------------
  logic        m_valid[2];
  logic [31:0] m_instr[2], m_pc[2], m_d1[2], m_d2[2], m_imm[2];
  logic [15:0] m_ctrl[2];
  int          m_owed[2], m_stall[2], m_bubble[2];

  function automatic int lcyc(int k);  return (k == 0) ? 1 : 3;      endfunction
  function automatic int cmax(int k);  return (k == 0) ? 65535 : 15; endfunction

  function automatic bit reads_reg(logic [31:0] ins, logic [4:0] r);
    logic [6:0] op;
    op = ins[6:0];
    if (op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111) return 1'b0;
    if (ins[19:15] == r) return 1'b1;
    if (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111) return 1'b0;
    return ins[24:20] == r;
  endfunction

  function automatic bit m_hazard(int k);
    return m_valid[k] && m_ctrl[k][1] && (m_instr[k][11:7] != 5'd0) && valid_in &&
           reads_reg(instr_in, m_instr[k][11:7]);
  endfunction

  function automatic bit m_stall_exp(int k);
    return !flush && (m_owed[k] > 0 || m_hazard(k));
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_valid[k] <= 1'b0; m_instr[k] <= 32'h13; m_pc[k] <= '0; m_d1[k] <= '0;
        m_d2[k] <= '0; m_imm[k] <= '0; m_ctrl[k] <= '0;
        m_owed[k] <= 0; m_stall[k] <= 0; m_bubble[k] <= 0;
      end else begin
        if ((m_stall_exp(k) || busywait) && m_stall[k] < cmax(k))
          m_stall[k] <= m_stall[k] + 1;
        if (!busywait) begin
          if (flush || m_owed[k] > 0 || m_hazard(k)) begin
            m_valid[k] <= 1'b0; m_instr[k] <= 32'h13; m_pc[k] <= '0; m_d1[k] <= '0;
            m_d2[k] <= '0; m_imm[k] <= '0; m_ctrl[k] <= '0;
            if (m_bubble[k] < cmax(k)) m_bubble[k] <= m_bubble[k] + 1;
            if (flush)            m_owed[k] <= 0;
            else if (m_owed[k] > 0) m_owed[k] <= m_owed[k] - 1;
            else                  m_owed[k] <= lcyc(k) - 1;
          end else begin
            m_valid[k] <= valid_in; m_instr[k] <= instr_in; m_pc[k] <= pc_in;
            m_d1[k] <= d1_in; m_d2[k] <= d2_in; m_imm[k] <= imm_in;
            m_ctrl[k] <= valid_in ? ctrl_in : 16'h0;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check32(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check1(string nm, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b, expected %0b", nm, act, exp);
    end
  endtask

  task automatic cmp_dut(int k, logic v, logic [31:0] ins, logic [31:0] pc,
                         logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
                         logic [15:0] ctrl, logic st, logic [15:0] sc, logic [15:0] bc);
    check1($sformatf("dut%0d valid_out", k), v, m_valid[k]);
    check32($sformatf("dut%0d instruction_out", k), ins, m_instr[k]);
    check32($sformatf("dut%0d PC_out", k), pc, m_pc[k]);
    check32($sformatf("dut%0d data1_out", k), d1, m_d1[k]);
    check32($sformatf("dut%0d data2_out", k), d2, m_d2[k]);
    check32($sformatf("dut%0d immediate_out", k), imm, m_imm[k]);
    check32($sformatf("dut%0d ctrl_out", k), {16'h0, ctrl}, {16'h0, m_ctrl[k]});
    check1($sformatf("dut%0d stall_ID", k), st, m_stall_exp(k));
    check32($sformatf("dut%0d stall_cnt", k), {16'h0, sc}, 32'(m_stall[k]));
    check32($sformatf("dut%0d bubble_cnt", k), {16'h0, bc}, 32'(m_bubble[k]));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      cmp_dut(0, if0.valid_out, if0.instruction_out, if0.PC_out, if0.data1_out,
              if0.data2_out, if0.immediate_out, if0.ctrl_out, if0.stall_ID,
              if0.stall_cnt, if0.bubble_cnt);
      cmp_dut(1, if1.valid_out, if1.instruction_out, if1.PC_out, if1.data1_out,
              if1.data2_out, if1.immediate_out, if1.ctrl_out, if1.stall_ID,
              {12'h0, if1.stall_cnt}, {12'h0, if1.bubble_cnt});
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] op_add(int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] op_lw(int rd, int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction

  task automatic set_id(logic v, logic [31:0] ins, logic [31:0] pc, logic [15:0] c);
    valid_in = v;
    instr_in = ins;
    pc_in    = pc;
    d1_in    = pc ^ 32'h1111_0000;
    d2_in    = pc ^ 32'h0000_2222;
    imm_in   = pc + 32'd4;
    ctrl_in  = c;
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [31:0] ld_tab[8], id_tab[8];
  logic        idv_tab[8], exp_tab[8];
  int          base;

  initial begin
    // LW then ID instruction; expected stall in the cycle the pair meets.
    ld_tab[0] = op_lw(5, 1); id_tab[0] = op_add(6, 0, 0);                          idv_tab[0] = 1; exp_tab[0] = 0;
    ld_tab[1] = op_lw(5, 1); id_tab[1] = {20'h12345, 5'd6, 7'b0110111};            idv_tab[1] = 1; exp_tab[1] = 0;
    ld_tab[2] = op_lw(5, 1); id_tab[2] = {12'd5, 5'd1, 3'b000, 5'd6, 7'b0010011};  idv_tab[2] = 1; exp_tab[2] = 0;
    ld_tab[3] = op_lw(5, 1); id_tab[3] = {7'd0, 5'd5, 5'd2, 3'b010, 5'd0, 7'b0100011}; idv_tab[3] = 1; exp_tab[3] = 1;
    ld_tab[4] = op_lw(0, 1); id_tab[4] = op_add(6, 0, 7);                          idv_tab[4] = 1; exp_tab[4] = 0;
    ld_tab[5] = op_lw(5, 1); id_tab[5] = {12'd0, 5'd5, 3'b000, 5'd1, 7'b1100111};  idv_tab[5] = 1; exp_tab[5] = 1;
    ld_tab[6] = op_lw(5, 1); id_tab[6] = {20'h00028, 5'd6, 7'b0010111};            idv_tab[6] = 1; exp_tab[6] = 0;
    ld_tab[7] = op_lw(5, 1); id_tab[7] = op_add(6, 5, 7);                          idv_tab[7] = 0; exp_tab[7] = 0;

    set_id(1'b0, 32'h0, 32'h0, 16'h0);
    busywait = 1'b0;
    flush    = 1'b0;
    tick(2);
    check1("rst valid0", if0.valid_out, 1'b0);
    check32("rst instr0", if0.instruction_out, 32'h13);
    check32("rst instr1", if1.instruction_out, 32'h13);
    check32("rst ctrl0", {16'h0, if0.ctrl_out}, 32'h0);
    check32("rst stall_cnt0", {16'h0, if0.stall_cnt}, 32'h0);
    reset = 1'b0;

    // Normal flow
    set_id(1'b1, op_add(3, 1, 2), 32'h100, 16'hA501);
    #1 check1("norm stall0", if0.stall_ID, 1'b0);
    tick(1);
    check1("norm valid0", if0.valid_out, 1'b1);
    check32("norm pc0", if0.PC_out, 32'h100);
    check32("norm ctrl0", {16'h0, if0.ctrl_out}, 32'hA501);
    check32("norm data1", if0.data1_out, 32'h1111_0100);
    check32("model pc0", m_pc[0], 32'h100);

    // Load-use: lw x5 then add x6,x5,x7
    set_id(1'b1, op_lw(5, 1), 32'h104, 16'h0003);
    tick(1);
    set_id(1'b1, op_add(6, 5, 7), 32'h108, 16'hA501);
    #1 check1("lu stall0", if0.stall_ID, 1'b1);
    check1("lu stall1", if1.stall_ID, 1'b1);
    tick(1);
    check1("lu bubble valid0", if0.valid_out, 1'b0);
    check32("lu bubble instr0", if0.instruction_out, 32'h13);
    check32("lu bubble_cnt0", {16'h0, if0.bubble_cnt}, 32'd1);
    check32("lu stall_cnt0", {16'h0, if0.stall_cnt}, 32'd1);
    check1("lu3 stall1 c2", if1.stall_ID, 1'b1);
    tick(1);
    check32("lu pc0", if0.PC_out, 32'h108);
    check1("lu3 valid1 c2", if1.valid_out, 1'b0);
    check1("lu3 stall1 c3", if1.stall_ID, 1'b1);
    tick(1);
    check1("lu3 stall1 end", if1.stall_ID, 1'b0);
    tick(1);
    check32("lu3 pc1", if1.PC_out, 32'h108);
    check32("lu3 bubble_cnt1", {28'h0, if1.bubble_cnt}, 32'd3);
    check32("lu3 stall_cnt1", {28'h0, if1.stall_cnt}, 32'd3);
    check32("model bubble1", 32'(m_bubble[1]), 32'd3);

    // Source-usage table
    for (int i = 0; i < 8; i++) begin
      base = 32'h400 + i * 16;
      set_id(1'b1, ld_tab[i], 32'(base), 16'h0003);
      tick(1);
      set_id(idv_tab[i], id_tab[i], 32'(base + 4), 16'h0001);
      #1 check1($sformatf("tab%0d stall0", i), if0.stall_ID, exp_tab[i]);
      check1($sformatf("tab%0d stall1", i), if1.stall_ID, exp_tab[i]);
      tick(1);
      set_id(1'b0, 32'h13, 32'h0, 16'h0);
      tick(3);
    end

    // Flush beats hazard
    set_id(1'b1, op_lw(5, 1), 32'h500, 16'h0003);
    tick(1);
    set_id(1'b1, op_add(6, 5, 7), 32'h504, 16'hA501);
    flush = 1'b1;
    #1 check1("fh stall0", if0.stall_ID, 1'b0);
    check1("fh stall1", if1.stall_ID, 1'b0);
    base = m_bubble[0];
    tick(1);
    flush = 1'b0;
    check1("fh valid0", if0.valid_out, 1'b0);
    check32("fh instr0", if0.instruction_out, 32'h13);
    check32("fh bubble_cnt0", {16'h0, if0.bubble_cnt}, 32'(base + 1));
    #1 check1("fh run1", if1.stall_ID, 1'b0);
    tick(1);

    // Flush while in HAZ
    set_id(1'b1, op_lw(5, 1), 32'h520, 16'h0003);
    tick(1);
    set_id(1'b1, op_add(6, 5, 7), 32'h524, 16'hA501);
    tick(1);
    flush = 1'b1;
    #1 check1("fhaz stall1", if1.stall_ID, 1'b0);
    tick(1);
    flush = 1'b0;
    #1 check1("fhaz run1", if1.stall_ID, 1'b0);
    set_id(1'b0, 32'h13, 32'h0, 16'h0);
    tick(1);

    // Memory stall freeze
    set_id(1'b1, op_add(3, 1, 2), 32'h200, 16'hA501);
    tick(1);
    set_id(1'b1, op_add(4, 1, 2), 32'h204, 16'hA501);
    busywait = 1'b1;
    base = m_stall[0];
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check32($sformatf("bw%0d pc0", i), if0.PC_out, 32'h200);
    end
    busywait = 1'b0;
    tick(1);
    check32("bw pc0 after", if0.PC_out, 32'h204);
    check32("bw stall_cnt0", {16'h0, if0.stall_cnt}, 32'(base + 4));

    // Memory stall during HAZ
    set_id(1'b1, op_lw(5, 1), 32'h210, 16'h0003);
    tick(1);
    set_id(1'b1, op_add(6, 5, 7), 32'h214, 16'hA501);
    tick(1);
    busywait = 1'b1;
    tick(2);
    check1("bwhaz stall1", if1.stall_ID, 1'b1);
    check1("bwhaz valid1", if1.valid_out, 1'b0);
    busywait = 1'b0;
    tick(2);
    check1("bwhaz done1", if1.stall_ID, 1'b0);
    tick(1);
    check32("bwhaz pc1", if1.PC_out, 32'h214);
    check32("sat stall_cnt1", {28'h0, if1.stall_cnt}, 32'hF);

    // Asynchronous reset while in HAZ
    set_id(1'b1, op_lw(5, 1), 32'h220, 16'h0003);
    tick(1);
    set_id(1'b1, op_add(6, 5, 7), 32'h224, 16'hA501);
    tick(1);
    #1 reset = 1'b1;
    #1;
    check1("arst valid1", if1.valid_out, 1'b0);
    check32("arst instr1", if1.instruction_out, 32'h13);
    check32("arst stall_cnt1", {28'h0, if1.stall_cnt}, 32'h0);
    check1("arst stall1", if1.stall_ID, 1'b0);
    tick(1);
    reset = 1'b0;
    set_id(1'b1, op_add(3, 1, 2), 32'h300, 16'hA501);
    tick(1);
    check1("post valid0", if0.valid_out, 1'b1);
    check32("post pc0", if0.PC_out, 32'h300);
    check32("post pc1", if1.PC_out, 32'h300);
    tick(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_hazard_pipe.md
# id_ex_hazard_pipe

Parametrised ID→EX pipeline register with built-in load-use hazard detection, bubble insertion, branch flush and memory-stall freeze. It sits between ID_Stage and EX_Stage. It replaces the fixed-width ID/EX register and takes over the stall logic previously scattered across the stages. It also provides saturating stall and bubble counters for performance debug.

## Interface

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- CTRL_W, 16, width of the opaque control bundle. Bit 0 = reg_write_en, bit 1 = is_load, bit 2 = mem_write; the remaining bits are passed through.
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard (≥1).
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- valid_in  in  1  ID holds a real instruction.
- instruction_in  in  32  ID instruction.
- PC_in  in  XLEN  ID PC.
- data1_in, data2_in  in  XLEN  ID operand mux outputs.
- immediate_in  in  XLEN  ID immediate.
- ctrl_in  in  CTRL_W  ID control bundle.
- busywait  in  1  memory stall; freeze everything.
- flush  in  1  branch/jump taken in EX (pc_select); kill the ID instruction.
- stall_ID  out  1  hold PC and IF/ID register this cycle.
- valid_out  out  1  EX holds a real instruction.
- instruction_out, PC_out, data1_out, data2_out, immediate_out, ctrl_out  out  matching widths  registered EX copies.
- stall_cnt  out  CNT_W  cycles with stall_ID or busywait high.
- bubble_cnt  out  CNT_W  bubbles inserted (hazard or flush).

## Operation

- Bubble definition: valid_out=0, ctrl_out=0, instruction_out=32'h00000013 (NOP). Other data outputs are don't-care; they are held at zero.
- Hazard detection is combinational. It requires valid_out & ctrl_out[1] & rd≠0 & valid_in & (rs1 match | rs2 match), with rd=instruction_out[11:7] and rs1/rs2 taken from instruction_in[19:15]/[24:20].
- Source usage by ID opcode:
  - LUI (0110111), AUIPC (0010111), JAL (1101111): no sources.
  - OP-IMM (0010011), LOAD (0000011), JALR (1100111): rs1 only.
  - All others: rs1 and rs2.
- FSM states: RUN, HAZ. There is also a down-counter hcnt with width clog2(LOAD_USE_CYCLES)+1.
- stall_ID = (RUN & hazard & ~flush) | (HAZ & ~flush).
- Edge action, in priority order:
  1. busywait: hold all registers, state and hcnt.
  2. flush: load bubble, state→RUN, hcnt→0.
  3. RUN & hazard: load bubble. If LOAD_USE_CYCLES>1, state→HAZ with hcnt=LOAD_USE_CYCLES−1.
  4. HAZ: load bubble, hcnt−1; on reaching 0, state→RUN.
  5. Otherwise: capture the ID inputs, with valid_out=valid_in.
- When valid_in=0, ctrl is captured as zero.
- Counters:
  - stall_cnt increments on each edge where stall_ID|busywait is high.
  - bubble_cnt increments on each edge executing action 2, 3 or 4.
  - Both saturate at all-ones, and neither increments during reset.

## Timing

- Reset values: all outputs 0 except instruction_out=32'h00000013; state RUN; hcnt 0; counters 0.
- Latency is 1 cycle ID→EX. stall_ID is valid in the same cycle as the offending ID instruction.
- Each load-use hazard costs exactly LOAD_USE_CYCLES bubbles. The stalled ID instruction is captured on the following free edge.
- flush and hazard in the same cycle: flush wins, stall_ID=0, one bubble.
- busywait during HAZ: hcnt is frozen and stall_ID stays high.
- Reset mid-HAZ returns the FSM to RUN immediately (asynchronous).

## Test plan

- Normal flow: add x3,x1,x2 at PC 0x100, valid → next edge valid_out=1, PC_out=0x100, ctrl and data match. stall_ID never asserts.
- Load-use: EX holds lw x5 (ctrl[1]=1), ID holds add x6,x5,x7 → stall_ID=1; next edge bubble (valid_out=0, NOP); add enters EX one edge later. bubble_cnt=1, stall_cnt=1.
- LOAD_USE_CYCLES=3 with the same pair → 3 consecutive bubbles and stall_ID high for 3 cycles. Add with rs=x0, or lui x6 after lw x5, → no stall.
- Flush versus hazard: load-use condition with flush=1 in the same cycle → stall_ID=0, bubble loaded, state RUN, bubble_cnt+1.
- busywait for 4 cycles mid-stream → all outputs frozen, stall_cnt+4. Afterwards, pending ID data is captured on the first free edge.
- Reset asserted asynchronously in HAZ between edges → outputs zero and instruction_out=0x13 immediately. After release, the first edge captures the ID inputs normally.
